// File: rtl/stream_pkg.sv
// rtl/stream_pkg.sv - shared helpers and constants for stream width converters
package stream_pkg;

    // Lane 0 (LSBs) carries the earliest beat in every width converter.
    localparam int STREAM_LANE_LSB_FIRST = 1;

    function automatic bit is_pow2(input int value);
        return (value > 0) && ((value & (value - 1)) == 0);
    endfunction

endpackage

// File: rtl/stream_width_packer_if.sv
// rtl/stream_width_packer_if.sv - narrow input stream and packed output stream of the width packer
interface stream_width_packer_if #(
    parameter int IN_WIDTH = 8,
    parameter int RATIO    = 4
);
    logic [IN_WIDTH-1:0]       in_data;
    logic                      in_valid;
    logic                      in_last;
    logic                      in_ready;
    logic [IN_WIDTH*RATIO-1:0] out_data;
    logic [RATIO-1:0]          out_keep;
    logic                      out_last;
    logic                      out_valid;
    logic                      out_ready;

    modport slave (
        input  in_data,
        input  in_valid,
        input  in_last,
        output in_ready,
        output out_data,
        output out_keep,
        output out_last,
        output out_valid,
        input  out_ready
    );

    modport master (
        output in_data,
        output in_valid,
        output in_last,
        input  in_ready,
        input  out_data,
        input  out_keep,
        input  out_last,
        input  out_valid,
        output out_ready
    );
endinterface

// File: rtl/stream_width_packer.sv
// rtl/stream_width_packer.sv - packs RATIO narrow beats into one wide word with keep mask and last flush
module stream_width_packer
    import stream_pkg::*;
#(
    parameter  int IN_WIDTH  = 8,
    parameter  int RATIO     = 4,
    localparam int OUT_WIDTH = IN_WIDTH * RATIO,
    localparam int LB_RATIO  = $clog2(RATIO)
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic                clear,
    stream_width_packer_if.slave s,
    output logic [LB_RATIO:0]   fill
);

    generate
        if (!is_pow2(RATIO) || RATIO < 2) begin : g_bad_ratio
            $error("stream_width_packer: RATIO must be a power of two and at least 2");
        end
        if (STREAM_LANE_LSB_FIRST != 1) begin : g_bad_lane_order
            $error("stream_width_packer: lane mapping assumes LSB-first lane order");
        end
    endgenerate

    localparam logic [LB_RATIO-1:0] LAST_IDX = LB_RATIO'(RATIO - 1);

    logic [OUT_WIDTH-1:0] acc_data;
    logic [RATIO-1:0]     acc_keep;
    logic [LB_RATIO-1:0]  idx;

    logic [OUT_WIDTH-1:0] word_data;
    logic [RATIO-1:0]     word_keep;
    logic                 in_exec;
    logic                 out_exec;
    logic                 word_done;

    assign s.in_ready = !s.out_valid || s.out_ready;
    assign in_exec    = s.in_valid && s.in_ready;
    assign out_exec   = s.out_valid && s.out_ready;
    assign word_done  = in_exec && ((idx == LAST_IDX) || s.in_last);
    assign fill       = {1'b0, idx};

    // Accumulator with the incoming beat merged in; lanes above idx are still zero.
    always_comb begin
        word_data = acc_data;
        word_keep = acc_keep;
        word_data[idx*IN_WIDTH +: IN_WIDTH] = s.in_data;
        word_keep[idx] = 1'b1;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            acc_data    <= '0;
            acc_keep    <= '0;
            idx         <= '0;
            s.out_data  <= '0;
            s.out_keep  <= '0;
            s.out_last  <= 1'b0;
            s.out_valid <= 1'b0;
        end else if (clear) begin
            acc_data    <= '0;
            acc_keep    <= '0;
            idx         <= '0;
            s.out_data  <= '0;
            s.out_keep  <= '0;
            s.out_last  <= 1'b0;
            s.out_valid <= 1'b0;
        end else begin
            if (word_done) begin
                acc_data    <= '0;
                acc_keep    <= '0;
                idx         <= '0;
                s.out_data  <= word_data;
                s.out_keep  <= word_keep;
                s.out_last  <= s.in_last;
                s.out_valid <= 1'b1;
            end else begin
                if (in_exec) begin
                    acc_data <= word_data;
                    acc_keep <= word_keep;
                    idx      <= idx + LB_RATIO'(1);
                end
                // Payload keeps its stale value after the sink takes it.
                if (out_exec) begin
                    s.out_valid <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_stream_width_packer.sv
// tb/tb_stream_width_packer.sv - randomized and directed checks of stream_width_packer against a queue model
module tb_stream_width_packer;

    localparam int IW = 8;
    localparam int R  = 4;

    logic       clk   = 1'b0;
    logic       rstn  = 1'b0;
    logic       clear = 1'b0;
    logic [2:0] fill;

    stream_width_packer_if #(.IN_WIDTH(IW), .RATIO(R)) bus();

    stream_width_packer #(.IN_WIDTH(IW), .RATIO(R)) dut (
        .clk   (clk),
        .rstn  (rstn),
        .clear (clear),
        .s     (bus),
        .fill  (fill)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    bit          m_valid = 1'b0;
    logic [31:0] m_data  = '0;
    logic [3:0]  m_keep  = '0;
    logic        m_last  = 1'b0;
    logic [7:0]  acc_q[$];
    logic [36:0] got_q[$];
    bit          watch_ready = 1'b0;
    bit          ready_dropped = 1'b0;
    bit          rnd_on = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Model: beats collect in a queue; a full queue or a last beat becomes the held word.
    always @(negedge clk) begin
        bit in_x, out_x, done;
        if (!rstn) begin
            m_valid = 1'b0; m_data = '0; m_keep = '0; m_last = 1'b0;
            acc_q.delete();
        end
        chk("in_ready", bus.in_ready, !m_valid || bus.out_ready);
        if (watch_ready && !bus.in_ready) ready_dropped = 1'b1;
        if (rstn) begin
            if (clear) begin
                m_valid = 1'b0; m_data = '0; m_keep = '0; m_last = 1'b0;
                acc_q.delete();
            end else begin
                if (bus.out_valid && bus.out_ready)
                    got_q.push_back({bus.out_last, bus.out_keep, bus.out_data});
                in_x  = bus.in_valid && (!m_valid || bus.out_ready);
                out_x = m_valid && bus.out_ready;
                done  = 1'b0;
                if (in_x) begin
                    acc_q.push_back(bus.in_data);
                    if (acc_q.size() == R || bus.in_last) begin
                        m_data = '0;
                        for (int i = 0; i < acc_q.size(); i++) m_data[i*8 +: 8] = acc_q[i];
                        m_keep  = 4'((1 << acc_q.size()) - 1);
                        m_last  = bus.in_last;
                        m_valid = 1'b1;
                        done    = 1'b1;
                        acc_q.delete();
                    end
                end
                if (out_x && !done) m_valid = 1'b0;
            end
        end
    end

    always @(posedge clk) begin
        #1;
        chk("out_valid", bus.out_valid, m_valid);
        chk("fill", fill, acc_q.size());
        if (m_valid) begin
            chk("out_data", bus.out_data, m_data);
            chk("out_keep", bus.out_keep, m_keep);
            chk("out_last", bus.out_last, m_last);
        end
    end

    task automatic send(input logic [7:0] d, input logic l);
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        bus.in_last  = l;
        for (int t = 0; t < 200; t++) begin
            @(negedge clk);
            if (bus.in_ready) begin
                @(posedge clk);
                #2;
                bus.in_valid = 1'b0;
                bus.in_last  = 1'b0;
                return;
            end
        end
        chk("send_timeout", 1, 0);
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
    endtask

    task automatic drain();
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b0;
        repeat (3) @(posedge clk);
        #2;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.in_last   = 1'b0;
        bus.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #2;
        chk("rst_valid", bus.out_valid, 0);
        chk("rst_fill", fill, 0);
        chk("rst_keep", bus.out_keep, 0);
        chk("rst_ready", bus.in_ready, 1);
        rstn = 1'b1;

        // 1: full word back-to-back
        send(8'h11, 0); send(8'h22, 0); send(8'h33, 0); send(8'h44, 0);
        chk("t1_valid", bus.out_valid, 1);
        chk("t1_data", bus.out_data, 32'h44332211);
        chk("t1_keep", bus.out_keep, 4'b1111);
        chk("t1_last", bus.out_last, 0);
        drain();
        got_q.delete();

        // 2: flush on last
        send(8'hAA, 0); send(8'hBB, 1);
        chk("t2_data", bus.out_data, 32'h0000BBAA);
        chk("t2_keep", bus.out_keep, 4'b0011);
        chk("t2_last", bus.out_last, 1);
        chk("t2_fill", fill, 0);
        drain();
        got_q.delete();

        // 3: backpressure
        bus.out_ready = 1'b0;
        send(8'h21, 0); send(8'h22, 0); send(8'h23, 0); send(8'h24, 0);
        bus.in_valid = 1'b1; bus.in_data = 8'h25;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            chk("t3_ready", bus.in_ready, 0);
            chk("t3_hold", bus.out_data, 32'h24232221);
        end
        @(posedge clk); #2;
        bus.out_ready = 1'b1;
        send(8'h25, 0); send(8'h26, 0); send(8'h27, 0); send(8'h28, 0);
        drain();
        chk("t3_cnt", got_q.size(), 2);
        chk("t3_w0", got_q[0], {1'b0, 4'hF, 32'h24232221});
        chk("t3_w1", got_q[1], {1'b0, 4'hF, 32'h28272625});
        got_q.delete();

        // 4: continuous stream
        watch_ready = 1'b1;
        for (int b = 0; b < 16; b++) send(8'(b), 0);
        watch_ready = 1'b0;
        drain();
        chk("t4_ready_drop", ready_dropped, 0);
        chk("t4_cnt", got_q.size(), 4);
        chk("t4_w0", got_q[0], {1'b0, 4'hF, 32'h03020100});
        chk("t4_w1", got_q[1], {1'b0, 4'hF, 32'h07060504});
        chk("t4_w2", got_q[2], {1'b0, 4'hF, 32'h0B0A0908});
        chk("t4_w3", got_q[3], {1'b0, 4'hF, 32'h0F0E0D0C});
        got_q.delete();

        // 5: clear drops held word and partial word
        bus.out_ready = 1'b0;
        send(8'h51, 0); send(8'h52, 0); send(8'h53, 0); send(8'h54, 0);
        clear = 1'b1;
        @(posedge clk); #2;
        clear = 1'b0;
        chk("t5_valid_a", bus.out_valid, 0);
        bus.out_ready = 1'b1;
        send(8'h01, 0); send(8'h02, 0);
        chk("t5_fill_a", fill, 2);
        clear = 1'b1;
        @(posedge clk); #2;
        clear = 1'b0;
        chk("t5_fill_b", fill, 0);
        chk("t5_valid_b", bus.out_valid, 0);
        send(8'h05, 0); send(8'h06, 0); send(8'h07, 0); send(8'h08, 0);
        chk("t5_data", bus.out_data, 32'h08070605);
        chk("t5_keep", bus.out_keep, 4'b1111);
        drain();
        chk("t5_cnt", got_q.size(), 1);
        got_q.delete();

        // 6: asynchronous reset mid-word
        send(8'hC0, 1);
        send(8'h61, 0); send(8'h62, 0);
        chk("t6_fill", fill, 2);
        #1;
        rstn = 1'b0;
        #1;
        chk("t6_valid", bus.out_valid, 0);
        chk("t6_fill0", fill, 0);
        chk("t6_keep", bus.out_keep, 0);
        chk("t6_data", bus.out_data, 0);
        @(posedge clk); #2;
        rstn = 1'b1;
        chk("t6_ready", bus.in_ready, 1);
        send(8'h71, 0); send(8'h72, 0); send(8'h73, 0); send(8'h74, 0);
        chk("t6_word", bus.out_data, 32'h74737271);
        drain();
        got_q.delete();

        // Random traffic against the model
        rnd_on = 1'b1;
        fork
            begin
                for (int n = 0; n < 400; n++) begin
                    if ($urandom_range(0, 3) == 0) begin
                        bus.in_valid = 1'b0;
                        @(posedge clk); #2;
                    end
                    send(8'($urandom), $urandom_range(0, 4) == 0);
                end
                rnd_on = 1'b0;
            end
            begin
                while (rnd_on) begin
                    @(posedge clk); #2;
                    if (rnd_on) begin
                        bus.out_ready = ($urandom_range(0, 9) < 7);
                        clear = ($urandom_range(0, 63) == 0);
                    end
                end
            end
        join
        clear = 1'b0;
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
